// File: rtl/jtvigil_obj_pkg.sv
// Shared types and constants for the Vigilante object scanner.
// Holds the FSM state encoding, the attribute-table byte layout and the sprite height helper.
package jtvigil_obj_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MATCH = 3'd2,
        FETCH = 3'd3,
        DRAW  = 3'd4,
        DONE  = 3'd5
    } obj_state_t;

    // Byte offsets inside one 8-byte table entry.
    localparam logic [2:0] OFS_PAL  = 3'd0;
    localparam logic [2:0] OFS_Y_LO = 3'd2;
    localparam logic [2:0] OFS_Y_HI = 3'd3;
    localparam logic [2:0] OFS_CODE = 3'd4;
    localparam logic [2:0] OFS_ATTR = 3'd5;
    localparam logic [2:0] OFS_X_LO = 3'd6;

    function automatic logic [8:0] obj_height(input logic [1:0] vsize);
        return 9'd16 << vsize;
    endfunction

endpackage

// File: rtl/jtvigil_obj_draw.sv
// ROM fetch handshake and pixel serialiser for one object.
// Fetches two 8-pixel halves and writes the opaque ones into the line buffer.
module jtvigil_obj_draw
    import jtvigil_obj_pkg::*;
#(
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          abort,
    input  logic          start,
    input  logic [CW-1:0] code,
    input  logic [3:0]    row,
    input  logic          hflip,
    input  logic [3:0]    pal,
    input  logic [8:0]    xpos,
    output logic [CW+4:0] rom_addr,
    output logic          rom_cs,
    input  logic          rom_ok,
    input  logic [31:0]   rom_data,
    output logic [8:0]    buf_addr,
    output logic [7:0]    buf_data,
    output logic          buf_we,
    output logic          done
);

    obj_state_t  state_r, state_s;
    logic [2:0]  pix_r;
    logic        half_r;
    logic        hflip_r;
    logic [3:0]  pal_r;
    logic [8:0]  xpos_r;
    logic [31:0] data_r;
    logic        sample_s;
    logic        last_pix_s;
    logic [2:0]  nib_sel_s;
    logic [3:0]  nib_s;
    logic [8:0]  x_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; an abort always wins
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_s = start ? FETCH : IDLE;
                FETCH:   state_s = sample_s ? DRAW : FETCH;
                DRAW:    state_s = last_pix_s ? (half_r ? IDLE : FETCH) : DRAW;
                default: state_s = IDLE;
            endcase
        end
    end

    // Output decode: ROM sample strobe and the current pixel nibble/position
    always_comb begin
        sample_s   = (state_r == FETCH) && rom_cs && rom_ok;
        last_pix_s = (state_r == DRAW) && (pix_r == 3'd7);
        nib_sel_s  = hflip_r ? ~pix_r : pix_r;
        nib_s      = data_r[{nib_sel_s, 2'b00} +: 4];
        x_s        = xpos_r + {5'd0, half_r, pix_r};
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
            rom_cs   <= 1'b0;
            buf_addr <= 9'd0;
            buf_data <= 8'd0;
            buf_we   <= 1'b0;
            done     <= 1'b0;
            pix_r    <= 3'd0;
            half_r   <= 1'b0;
            hflip_r  <= 1'b0;
            pal_r    <= 4'd0;
            xpos_r   <= 9'd0;
            data_r   <= 32'd0;
        end else begin
            rom_cs <= (state_s == FETCH);
            // Raised during the final pixel so the scanner moves on without a gap
            done   <= (state_r == DRAW) && (pix_r == 3'd6) && half_r && !abort;
            buf_we <= (state_r == DRAW) && !abort && (nib_s != 4'd0);
            if (state_r == DRAW) begin
                buf_addr <= x_s;
                buf_data <= {pal_r, nib_s};
                pix_r    <= pix_r + 3'd1;
            end
            if ((state_r == IDLE) && start && !abort) begin
                rom_addr <= {code, row, hflip};
                half_r   <= 1'b0;
                hflip_r  <= hflip;
                pal_r    <= pal;
                xpos_r   <= xpos;
            end else if (last_pix_s && !half_r) begin
                rom_addr[0] <= ~hflip_r;
                half_r      <= 1'b1;
            end
            if (sample_s) begin
                data_r <= rom_data;
                pix_r  <= 3'd0;
            end
        end
    end

endmodule

// File: rtl/jtvigil_obj_scan.sv
// Vigilante sprite scanner: per-line attribute table scan, match and hand-off to the draw engine.
// Define JTVIGIL_OBJ_LIMIT_EN to stop a line after MAXLINE objects have been drawn.
module jtvigil_obj_scan
    import jtvigil_obj_pkg::*;
#(
    parameter int OBJW    = 5,
    parameter int CW      = 12,
    parameter int MAXLINE = 16
) (
    input  logic            rst,
    input  logic            clk,
    input  logic            LHBL,
    input  logic [8:0]      v,
    output logic [OBJW+2:0] scan_addr,
    input  logic [7:0]      scan_dout,
    output logic [CW+4:0]   rom_addr,
    output logic            rom_cs,
    input  logic            rom_ok,
    input  logic [31:0]     rom_data,
    output logic [8:0]      buf_addr,
    output logic [7:0]      buf_data,
    output logic            buf_we,
    output logic            busy
);

`ifdef JTVIGIL_OBJ_LIMIT_EN
    localparam logic LIMIT_EN = 1'b1;
`else
    localparam logic LIMIT_EN = 1'b0;
`endif
    localparam logic [OBJW-1:0] OBJ_ONE = {{(OBJW-1){1'b0}}, 1'b1};
    localparam logic [OBJW:0]   CNT_ONE = {{OBJW{1'b0}}, 1'b1};
    localparam logic [OBJW:0]   CNT_MAX = (OBJW+1)'(MAXLINE);

    obj_state_t    state_r, state_s;
    logic          lhbl_r;
    logic          fall_s;
    logic [8:0]    vr_r;
    logic [OBJW-1:0] obj_r, obj_nxt_s;
    logic          last_r, last_s;
    logic [OBJW:0] count_r, count_nxt_s;
    logic [2:0]    rd_cnt_r, byte_idx_s;
    logic [3:0]    pal_r;
    logic [7:0]    y_lo_r, code_lo_r, attr_r, x_lo_r;
    logic          y_hi_r;
    logic [8:0]    ydiff_s, height_s;
    logic [6:0]    row_s;
    logic [CW-1:0] code_eff_s;
    logic          match_s, start_s, limit_s, draw_done_s;

    assign fall_s      = lhbl_r & ~LHBL;
    assign obj_nxt_s   = obj_r + OBJ_ONE;
    assign count_nxt_s = count_r + CNT_ONE;
    assign byte_idx_s  = rd_cnt_r - 3'd1;
    assign limit_s     = LIMIT_EN && (count_nxt_s == CNT_MAX);

    // Vertical match, row within the sprite and the effective tile code
    always_comb begin
        ydiff_s    = vr_r - {y_hi_r, y_lo_r};
        height_s   = obj_height(attr_r[5:4]);
        match_s    = ydiff_s < height_s;
        row_s      = attr_r[7] ? (height_s[6:0] - 7'd1 - ydiff_s[6:0]) : ydiff_s[6:0];
        code_eff_s = CW'({attr_r[3:0], code_lo_r}) + CW'(row_s[6:4]);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a new line start restarts from any state
    always_comb begin
        state_s = state_r;
        if (fall_s) begin
            state_s = READ;
        end else begin
            case (state_r)
                IDLE:    state_s = IDLE;
                READ:    state_s = (rd_cnt_r == 3'd7) ? MATCH : READ;
                MATCH:   state_s = match_s ? FETCH : (last_s ? DONE : READ);
                FETCH:   state_s = draw_done_s ? ((last_r || limit_s) ? DONE : READ) : FETCH;
                DONE:    state_s = DONE;
                default: state_s = IDLE;
            endcase
        end
    end

    // Output decode: draw start and last-entry flag
    always_comb begin
        start_s = 1'b0;
        last_s  = 1'b0;
        if (state_r == MATCH) begin
            start_s = match_s && !fall_s;
            last_s  = (obj_r == {OBJW{1'b1}});
        end else begin
            start_s = 1'b0;
            last_s  = 1'b0;
        end
    end

    // Table read sequencing, byte capture and line bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            lhbl_r    <= 1'b0;
            vr_r      <= 9'd0;
            obj_r     <= '0;
            last_r    <= 1'b0;
            count_r   <= '0;
            rd_cnt_r  <= 3'd0;
            scan_addr <= '0;
            pal_r     <= 4'd0;
            y_lo_r    <= 8'd0;
            y_hi_r    <= 1'b0;
            code_lo_r <= 8'd0;
            attr_r    <= 8'd0;
            x_lo_r    <= 8'd0;
            busy      <= 1'b0;
        end else begin
            lhbl_r <= LHBL;
            busy   <= (state_s == READ) || (state_s == MATCH) || (state_s == FETCH);
            if (fall_s) begin
                vr_r      <= v + 9'd1;
                obj_r     <= '0;
                last_r    <= 1'b0;
                count_r   <= '0;
                rd_cnt_r  <= 3'd0;
                scan_addr <= '0;
            end else begin
                case (state_r)
                    READ: begin
                        rd_cnt_r <= rd_cnt_r + 3'd1;
                        if (rd_cnt_r != 3'd7) begin
                            scan_addr <= {obj_r, rd_cnt_r + 3'd1};
                        end
                        // Data lags the address by one clock
                        if (rd_cnt_r != 3'd0) begin
                            case (byte_idx_s)
                                OFS_PAL:  pal_r     <= scan_dout[3:0];
                                OFS_Y_LO: y_lo_r    <= scan_dout;
                                OFS_Y_HI: y_hi_r    <= scan_dout[0];
                                OFS_CODE: code_lo_r <= scan_dout;
                                OFS_ATTR: attr_r    <= scan_dout;
                                OFS_X_LO: x_lo_r    <= scan_dout;
                                default:  ;
                            endcase
                        end
                    end
                    MATCH: begin
                        obj_r     <= obj_nxt_s;
                        last_r    <= last_s;
                        scan_addr <= {obj_nxt_s, 3'd0};
                        rd_cnt_r  <= 3'd0;
                    end
                    FETCH: begin
                        if (draw_done_s) begin
                            count_r <= count_nxt_s;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // xpos MSB (byte 7) arrives during MATCH and goes straight to the draw engine
    jtvigil_obj_draw #(.CW(CW)) u_draw (
        .clk      (clk),
        .rst      (rst),
        .abort    (fall_s),
        .start    (start_s),
        .code     (code_eff_s),
        .row      (row_s[3:0]),
        .hflip    (attr_r[6]),
        .pal      (pal_r),
        .xpos     ({scan_dout[0], x_lo_r}),
        .rom_addr (rom_addr),
        .rom_cs   (rom_cs),
        .rom_ok   (rom_ok),
        .rom_data (rom_data),
        .buf_addr (buf_addr),
        .buf_data (buf_data),
        .buf_we   (buf_we),
        .done     (draw_done_s)
    );

endmodule

// File: tb/tb_jtvigil_obj_scan.sv
// Scoreboard bench for jtvigil_obj_scan: table and ROM models, expected ROM addresses and
// line-buffer writes queued at setup time and compared as the design produces them.
module tb_jtvigil_obj_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        LHBL;
    logic [8:0]  v;
    logic [7:0]  scan_addr;
    logic [7:0]  scan_dout;
    logic [16:0] rom_addr;
    logic        rom_cs;
    logic        rom_ok = 1'b0;
    logic [31:0] rom_data = 32'd0;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_data;
    logic        buf_we;
    logic        busy;

    jtvigil_obj_scan dut (
        .rst(rst), .clk(clk), .LHBL(LHBL), .v(v),
        .scan_addr(scan_addr), .scan_dout(scan_dout),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
        .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:255];
    logic [16:0] exp_rom[$];
    logic [16:0] exp_wr[$];
    logic [16:0] wr_log[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          rom_dly = 0;
    int          rom_wait = 0;
    int          n_fetch = 0;
    logic [31:0] rom_word = 32'd0;
    logic [16:0] rom_first = 17'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Object table: data one clock after the address
    always @(posedge clk) scan_dout <= mem[scan_addr];

    // ROM model: answers after rom_dly clocks of rom_cs, checks the address it was asked for
    always @(negedge clk) begin
        if (rst) begin
            rom_ok = 1'b0; rom_wait = 0;
        end else if (rom_ok) begin
            rom_ok = 1'b0; rom_wait = 0;
        end else if (rom_cs) begin
            if (rom_wait == 0) rom_first = rom_addr;
            if (rom_wait >= rom_dly) begin
                rom_ok   = 1'b1;
                rom_data = rom_word;
                n_fetch++;
                if (exp_rom.size() == 0) chk("rom_unexp", {31'd0, rom_cs}, 32'd0);
                else chk("rom_addr", {15'd0, rom_addr}, {15'd0, exp_rom.pop_front()});
                if (rom_dly > 0) chk("rom_hold", {15'd0, rom_addr}, {15'd0, rom_first});
            end else begin
                rom_wait++;
            end
        end else begin
            rom_wait = 0;
        end
    end

    // Line-buffer monitor
    always @(negedge clk) begin
        if (!rst && buf_we) begin
            wr_log.push_back({buf_addr, buf_data});
            if (exp_wr.size() == 0) chk("wr_unexp", {31'd0, buf_we}, 32'd0);
            else chk("wr", {15'd0, buf_addr, buf_data}, {15'd0, exp_wr.pop_front()});
        end
    end

    task automatic clear_tab();
        for (int i = 0; i < 32; i++) begin
            for (int b = 0; b < 8; b++) mem[i*8+b] = 8'h00;
            mem[i*8+2] = 8'hF0;   // ypos = 496: never on the lines used here
            mem[i*8+3] = 8'h01;
        end
    endtask

    task automatic set_obj(input int i, input logic [8:0] y, input logic [11:0] code,
                           input logic [1:0] vs, input logic vf, input logic hf,
                           input logic [3:0] pal, input logic [8:0] x);
        mem[i*8+0] = {4'hA, pal};
        mem[i*8+1] = 8'h5C;
        mem[i*8+2] = y[7:0];
        mem[i*8+3] = {7'h7F, y[8]};
        mem[i*8+4] = code[7:0];
        mem[i*8+5] = {vf, hf, vs, code[11:8]};
        mem[i*8+6] = x[7:0];
        mem[i*8+7] = {7'h55, x[8]};
    endtask

    task automatic push_obj(input logic [11:0] code, input logic [3:0] row, input logic hf,
                            input logic [3:0] pal, input logic [8:0] x, input logic [31:0] w);
        logic [3:0] nib;
        logic [8:0] a;
        for (int h = 0; h < 2; h++) begin
            exp_rom.push_back({code, row, (h == 1) ^ hf});
            for (int i = 0; i < 8; i++) begin
                nib = hf ? w[4*(7-i) +: 4] : w[4*i +: 4];
                a   = x + 9'(8*h + i);
                if (nib != 4'd0) exp_wr.push_back({a, pal, nib});
            end
        end
    endtask

    task automatic run_line(input logic [8:0] vl, output int cyc);
        @(negedge clk);
        v = vl; LHBL = 1'b1;
        repeat (2) @(negedge clk);
        LHBL = 1'b0;
        @(negedge clk);
        cyc = 0;
        while (busy === 1'b1 && cyc < 4000) begin
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 4000) chk("line_timeout", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        LHBL = 1'b1;
        chk("wr_left", exp_wr.size(), 32'd0);
        chk("rom_left", exp_rom.size(), 32'd0);
    endtask

    int cyc, base, fbase, n_draw, k;

    initial begin
        rst = 1'b1; LHBL = 1'b1; v = 9'd0;
        clear_tab();
        repeat (4) @(negedge clk);
        chk("rst_rom_cs", {31'd0, rom_cs}, 32'd0);
        chk("rst_buf_we", {31'd0, buf_we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_buf_addr", {23'd0, buf_addr}, 32'd0);
        chk("rst_buf_data", {24'd0, buf_data}, 32'd0);
        chk("rst_scan_addr", {24'd0, scan_addr}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Plain object, all nibbles opaque
        rom_word = 32'h87654321; rom_dly = 0;
        set_obj(0, 9'd100, 12'h123, 2'd0, 1'b0, 1'b0, 4'h5, 9'd40);
        push_obj(12'h123, 4'd0, 1'b0, 4'h5, 9'd40, rom_word);
        base = wr_log.size();
        run_line(9'd99, cyc);
        chk("t1_cycles", cyc, 32'd306);
        chk("t1_writes", wr_log.size() - base, 32'd16);
        if (wr_log.size() > base) chk("t1_first", {15'd0, wr_log[base]}, {15'd0, 9'd40, 8'h51});

        // Horizontal flip
        set_obj(0, 9'd100, 12'h123, 2'd0, 1'b0, 1'b1, 4'h5, 9'd40);
        push_obj(12'h123, 4'd0, 1'b1, 4'h5, 9'd40, rom_word);
        base = wr_log.size();
        run_line(9'd99, cyc);
        if (wr_log.size() > base) chk("t2_x40_pix8", {15'd0, wr_log[base]}, {15'd0, 9'd40, 8'h58});
        else chk("t2_no_write", wr_log.size(), base + 1);

        // Tall object with vertical flip, x wrapping past 511
        set_obj(0, 9'd10, 12'h200, 2'd2, 1'b1, 1'b0, 4'h3, 9'd505);
        push_obj(12'h203, 4'hF, 1'b0, 4'h3, 9'd505, rom_word);
        run_line(9'd9, cyc);
        chk("t3_cycles", cyc, 32'd306);

        // Fully transparent graphics
        rom_word = 32'h00000000;
        set_obj(0, 9'd100, 12'h123, 2'd0, 1'b0, 1'b0, 4'h5, 9'd40);
        push_obj(12'h123, 4'd0, 1'b0, 4'h5, 9'd40, rom_word);
        base = wr_log.size();
        run_line(9'd99, cyc);
        chk("t4_writes", wr_log.size() - base, 32'd0);

        // Slow ROM: 5 extra clocks per fetch
        rom_word = 32'h0F0F1111; rom_dly = 5;
        push_obj(12'h123, 4'd0, 1'b0, 4'h5, 9'd40, rom_word);
        run_line(9'd99, cyc);
        chk("t5_cycles", cyc, 32'd316);
        rom_dly = 0;

        // Twenty objects on one line
        clear_tab();
        rom_word = 32'h12345678;
`ifdef JTVIGIL_OBJ_LIMIT_EN
        n_draw = 16;
`else
        n_draw = 20;
`endif
        for (k = 0; k < 20; k++) begin
            set_obj(k, 9'd50, 12'h010 + 12'(k), 2'd0, 1'b0, 1'b0, 4'(k), 9'(k*8));
            if (k < n_draw) push_obj(12'h010 + 12'(k), 4'd0, 1'b0, 4'(k), 9'(k*8), rom_word);
        end
        fbase = n_fetch;
        run_line(9'd49, cyc);
        chk("t6_fetches", n_fetch - fbase, 2 * n_draw);

        // New line start while a fetch is pending
        clear_tab();
        rom_dly = 50; rom_word = 32'h87654321;
        set_obj(0, 9'd100, 12'h123, 2'd0, 1'b0, 1'b0, 4'h5, 9'd40);
        @(negedge clk); v = 9'd99; LHBL = 1'b1;
        repeat (2) @(negedge clk);
        LHBL = 1'b0;
        cyc = 0;
        while (rom_cs !== 1'b1 && cyc < 200) begin cyc++; @(negedge clk); end
        chk("t7_fetch_seen", {31'd0, rom_cs}, 32'd1);
        @(negedge clk); LHBL = 1'b1; v = 9'd104;
        @(negedge clk); LHBL = 1'b0;
        @(negedge clk);
        chk("t7_rom_cs_drop", {31'd0, rom_cs}, 32'd0);
        chk("t7_scan_restart", {24'd0, scan_addr}, 32'd0);
        rom_dly = 0;
        push_obj(12'h123, 4'd5, 1'b0, 4'h5, 9'd40, rom_word);
        cyc = 0;
        while (busy === 1'b1 && cyc < 4000) begin cyc++; @(negedge clk); end
        chk("t7_done", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("t7_wr_left", exp_wr.size(), 32'd0);
        chk("t7_rom_left", exp_rom.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
